// File: rtl/row_dot_accumulator.sv
// Row dot-product accumulator: pipelined NI-lane adder tree feeding a row accumulator.
// Define RDA_SATURATE_EN for saturating arithmetic and the sat_flag output.
module row_dot_accumulator #(
   parameter int NI     = 8,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic                 in_last,
   input  logic [NI*DATA_W-1:0] adder_row_input,
   output logic [DATA_W-1:0]    adder_output,
   output logic                 out_valid,
   output logic [CNT_W-1:0]     beat_count,
   output logic                 busy
`ifdef RDA_SATURATE_EN
   ,
   output logic                 sat_flag
`endif
);

   localparam int L = $clog2(NI);
`ifdef RDA_SATURATE_EN
   localparam int TW = DATA_W + L;
`else
   localparam int TW = DATA_W;
`endif
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Heap-ordered tree: node n sums nodes 2n and 2n+1; leaves are NI..2*NI-1, root is 1.
   logic [TW-1:0]     node_r [1:2*NI-1];
   logic [L:0]        vld_r;
   logic [L:0]        lst_r;
   logic [DATA_W-1:0] acc_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              acc_empty_r;
   logic [DATA_W-1:0] tree_sum_s;
   logic [DATA_W-1:0] acc_sum_s;
   logic [DATA_W-1:0] acc_next_s;
   logic [CNT_W-1:0]  cnt_next_s;

`ifdef RDA_SATURATE_EN
   logic              row_ovf_r;
   logic              tree_ovf_s;
   logic              acc_ovf_s;
   logic [DATA_W:0]   acc_ext_s;
   logic              row_ovf_next_s;

   function automatic logic [DATA_W-1:0] sat_val(input logic neg);
      sat_val = neg ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
   endfunction

   // Out of range when the guard bits and the DATA_W sign bit disagree.
   function automatic logic tree_ovf(input logic [TW-1:0] v);
      tree_ovf = !((&v[TW-1:DATA_W-1]) || !(|v[TW-1:DATA_W-1]));
   endfunction

   function automatic logic [DATA_W:0] add_ext(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
      add_ext = {a[DATA_W-1], a} + {b[DATA_W-1], b};
   endfunction
`endif

   // Valid/last travel with the data, one stage per tree level; start=0 flushes them.
   always_ff @(posedge clk) begin
      if (rst || !start) begin
         vld_r <= '0;
         lst_r <= '0;
      end else begin
         vld_r <= {vld_r[L-1:0], in_valid};
         lst_r <= {lst_r[L-1:0], in_valid & in_last};
      end
   end

   // Tree data path: leaves capture the lanes, every inner node adds its two children.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 1; n < 2*NI; n++) begin
            node_r[n] <= '0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            node_r[NI+i] <= TW'($signed(adder_row_input[i*DATA_W +: DATA_W]));
         end
         for (int n = 1; n < NI; n++) begin
            node_r[n] <= node_r[2*n] + node_r[2*n+1];
         end
      end
   end

   // Next accumulator/count values for the beat leaving the tree.
   always_comb begin
`ifdef RDA_SATURATE_EN
      tree_ovf_s = tree_ovf(node_r[1]);
      tree_sum_s = tree_ovf_s ? sat_val(node_r[1][TW-1]) : node_r[1][DATA_W-1:0];
      acc_ext_s  = add_ext(acc_r, tree_sum_s);
      acc_ovf_s  = acc_ext_s[DATA_W] ^ acc_ext_s[DATA_W-1];
      acc_sum_s  = acc_ovf_s ? sat_val(acc_ext_s[DATA_W]) : acc_ext_s[DATA_W-1:0];
      row_ovf_next_s = 1'b0;
`else
      tree_sum_s = node_r[1][DATA_W-1:0];
      acc_sum_s  = acc_r + tree_sum_s;
`endif
      acc_next_s = acc_sum_s;
      cnt_next_s = cnt_r;
      if (acc_empty_r) begin
         acc_next_s = tree_sum_s;
         cnt_next_s = CNT_ONE;
`ifdef RDA_SATURATE_EN
         row_ovf_next_s = tree_ovf_s;
`endif
      end else begin
         acc_next_s = acc_sum_s;
         cnt_next_s = (cnt_r == CNT_MAX) ? CNT_MAX : cnt_r + CNT_ONE;
`ifdef RDA_SATURATE_EN
         row_ovf_next_s = row_ovf_r | tree_ovf_s | acc_ovf_s;
`endif
      end
   end

   // Accumulate non-last beats; a last beat emits the row and empties the accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r        <= '0;
         cnt_r        <= '0;
         acc_empty_r  <= 1'b1;
         adder_output <= '0;
         beat_count   <= '0;
         out_valid    <= 1'b0;
`ifdef RDA_SATURATE_EN
         row_ovf_r    <= 1'b0;
         sat_flag     <= 1'b0;
`endif
      end else if (!start) begin
         acc_empty_r  <= 1'b1;
         out_valid    <= 1'b0;
`ifdef RDA_SATURATE_EN
         sat_flag     <= 1'b0;
`endif
      end else begin
         out_valid    <= 1'b0;
`ifdef RDA_SATURATE_EN
         sat_flag     <= 1'b0;
`endif
         if (vld_r[L]) begin
            if (lst_r[L]) begin
               adder_output <= acc_next_s;
               beat_count   <= cnt_next_s;
               out_valid    <= 1'b1;
               acc_empty_r  <= 1'b1;
`ifdef RDA_SATURATE_EN
               sat_flag     <= row_ovf_next_s;
`endif
            end else begin
               acc_r        <= acc_next_s;
               cnt_r        <= cnt_next_s;
               acc_empty_r  <= 1'b0;
`ifdef RDA_SATURATE_EN
               row_ovf_r    <= row_ovf_next_s;
`endif
            end
         end
      end
   end

   assign busy = (|vld_r) | ~acc_empty_r;

endmodule

// File: tb/tb_row_dot_accumulator.sv
// Scoreboard bench for row_dot_accumulator (NI=8, DATA_W=32): directed rows then random rows.
// Expected rows come from whole-row arithmetic on the applied lanes.
module tb_row_dot_accumulator;

   localparam int LAT = 4;

   logic         clk = 1'b0;
   logic         rst, start, in_valid, in_last;
   logic [255:0] row_in;
   logic [31:0]  adder_output;
   logic         out_valid, busy;
   logic [15:0]  beat_count;
`ifdef RDA_SATURATE_EN
   logic         sat_flag;
`endif

   row_dot_accumulator #(.NI(8), .DATA_W(32), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
      .adder_row_input(row_in), .adder_output(adder_output), .out_valid(out_valid),
      .beat_count(beat_count), .busy(busy)
`ifdef RDA_SATURATE_EN
      , .sat_flag(sat_flag)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] sum;
      int          cnt;
      bit          sat;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;
   longint      m_acc = 0;
   int          m_cnt = 0;
   bit          m_sat = 0;
   logic [31:0] last_exp = 32'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every out_valid pulse is matched against the oldest expected row.
   always @(posedge clk) begin
      #1;
      if (out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("spurious_out_valid", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("row_sum", adder_output, e.sum);
            chk("beat_count", beat_count, e.cnt);
            chk("latency_cycle", cyc, e.cyc);
`ifdef RDA_SATURATE_EN
            chk("sat_flag", sat_flag, e.sat);
`endif
         end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
         chk("missing_out_valid", cyc, sb[0].cyc);
         void'(sb.pop_front());
      end
   end

   function automatic longint clamp32(input longint v, inout bit s);
      if (v > 64'sd2147483647) begin s = 1'b1; return 64'sd2147483647; end
      if (v < -64'sd2147483648) begin s = 1'b1; return -64'sd2147483648; end
      return v;
   endfunction

   function automatic logic [255:0] fill(input logic [31:0] x);
      return {8{x}};
   endfunction

   task automatic model_clear();
      m_acc = 0;
      m_cnt = 0;
      m_sat = 1'b0;
   endtask

   task automatic beat(input logic [255:0] v, input bit last);
      longint bs;
      @(negedge clk);
      in_valid = 1'b1;
      in_last  = last;
      row_in   = v;
      bs = 0;
      for (int i = 0; i < 8; i++) bs += longint'($signed(v[i*32 +: 32]));
`ifdef RDA_SATURATE_EN
      bs = clamp32(bs, m_sat);
      m_acc = (m_cnt == 0) ? bs : clamp32(m_acc + bs, m_sat);
`else
      m_acc += bs;
`endif
      if (m_cnt < 65535) m_cnt++;
      if (last) begin
         e.sum = m_acc[31:0];
         e.cnt = m_cnt;
         e.sat = m_sat;
         e.cyc = cyc + 1 + LAT;
         sb.push_back(e);
         last_exp = m_acc[31:0];
         model_clear();
      end
   endtask

   // Idle cycles carry junk data and a random in_last, all of which must be ignored.
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_last  = 1'($urandom_range(0, 1));
         row_in   = {8{$urandom}};
      end
   endtask

   task automatic drain_and_check_idle();
      int t = 0;
      idle(1);
      while (sb.size() != 0 && t < 60) begin
         @(negedge clk);
         t++;
      end
      idle(2);
      chk("drain_queue_empty", sb.size(), 0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_output_held", adder_output, last_exp);
   endtask

   initial begin
      logic [255:0] v;
      int           nb;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; row_in = '0;
      repeat (3) @(negedge clk);
      chk("reset_adder_output", adder_output, 32'd0);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_beat_count", beat_count, 16'd0);
      chk("reset_busy", busy, 1'b0);
      rst = 1'b0; start = 1'b1;

      // Three beats of ones, last on beat three -> 24, 3 beats.
      beat(fill(32'd1), 1'b0); beat(fill(32'd1), 1'b0); beat(fill(32'd1), 1'b1);
      drain_and_check_idle();

      // Single beat lanes 1..8 -> 36.
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'(i + 1);
      beat(v, 1'b1);
      drain_and_check_idle();

      // Back-to-back single-beat rows -> 16 then 24 on consecutive cycles.
      beat(fill(32'd2), 1'b1); beat(fill(32'd3), 1'b1);
      drain_and_check_idle();

      // Bubbles inside a row hold the accumulator -> 16.
      beat(fill(32'd1), 1'b0);
      idle(2);
      chk("busy_mid_row", busy, 1'b1);
      beat(fill(32'd1), 1'b1);
      drain_and_check_idle();

      // Reset mid-row discards the partial sum.
      beat(fill(32'd1), 1'b0); beat(fill(32'd1), 1'b0);
      @(negedge clk); rst = 1'b1; in_valid = 1'b0;
      @(negedge clk); rst = 1'b0;
      model_clear();
      last_exp = 32'd0;
      chk("midrow_reset_output", adder_output, 32'd0);
      chk("midrow_reset_count", beat_count, 16'd0);
      idle(6);
      beat(fill(32'd5), 1'b1);
      drain_and_check_idle();

      // Dropping start mid-row flushes it while outputs keep their values.
      beat(fill(32'd1), 1'b0); beat(fill(32'd1), 1'b0);
      @(negedge clk); start = 1'b0; in_valid = 1'b1; in_last = 1'b1; row_in = fill(32'd9);
      @(negedge clk);
      @(negedge clk);
      chk("start_low_output_held", adder_output, 32'd40);
      chk("start_low_count_held", beat_count, 16'd1);
      chk("start_low_busy", busy, 1'b0);
      start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      model_clear();
      idle(5);
      beat(fill(32'd4), 1'b1);
      drain_and_check_idle();

      // Overflow: all lanes at the positive limit.
      beat(fill(32'h7FFF_FFFF), 1'b1);
      drain_and_check_idle();

      // Random rows with random bubbles and back-to-back starts.
      for (int r = 0; r < 40; r++) begin
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 8; i++) begin
               if ($urandom_range(0, 3) == 0) v[i*32 +: 32] = $urandom;
               else v[i*32 +: 32] = 32'($urandom_range(0, 2000)) - 32'd1000;
            end
            beat(v, b == nb - 1);
            if (b < nb - 1) idle($urandom_range(0, 2));
         end
         idle($urandom_range(0, 1));
      end
      drain_and_check_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/row_dot_accumulator.md
Name: row_dot_accumulator

Overview:
- Parametrised successor to the fixed 8-lane row adder/accumulator used in the matrix-vector datapath.
- Each valid beat carries NI lanes, which are reduced by a fully pipelined binary adder tree.
- Consecutive beats are accumulated into one dot-product result until a beat flagged last arrives. The result is then emitted with a one-cycle out_valid pulse.
- Replaces the hand-counted valid delay chain with an internally derived, parameter-tracked valid/last pipeline. Back-to-back rows are supported with no bubble.

Parameters:
- NI, 8, lane count per beat; power of two, 2..64.
- DATA_W, 32, lane and result width; two's-complement integer.
- CNT_W, 16, width of the beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  run enable; low means flush/clear, as in the current row organizer.
- in_valid  input  1  the beat on adder_row_input is valid this cycle.
- in_last  input  1  final beat of the current row; qualified by in_valid.
- adder_row_input  input  NI*DATA_W  lanes; lane i occupies bits [i*DATA_W +: DATA_W].
- adder_output  output  DATA_W  completed row sum; held until the next out_valid.
- out_valid  output  1  one-cycle pulse, adder_output is new.
- beat_count  output  CNT_W  number of beats in the row just emitted; updates with out_valid.
- busy  output  1  high while any valid beat is in the tree or the accumulator is non-empty.

Behaviour:
- Reset (rst=1 at a clk edge):
  - adder_output=0, out_valid=0, beat_count=0, busy=0.
  - All tree valid/last stages cleared; accumulator emptied.
  - rst has priority over everything, including mid-row operation: partial sums are discarded and no out_valid follows.
- start=0:
  - Same clearing effect as rst on the tree valids, the accumulator and out_valid.
  - adder_output and beat_count keep their last values.
  - Inputs are ignored.
- Tree:
  - L=log2(NI) registered levels; each level adds adjacent pairs.
  - Sums wrap modulo 2^DATA_W.
  - valid and last shift alongside the data, one stage per level.
- Accumulator stage (one register after the tree):
  - On tree-out valid with the accumulator empty: acc <= tree_sum, cnt <= 1.
  - Otherwise on tree-out valid: acc <= acc + tree_sum (wrap), cnt <= cnt + 1.
  - cnt saturates at 2^CNT_W-1.
- Emit:
  - When the tree-out beat has last=1: adder_output <= the new acc value, beat_count <= the new cnt value, out_valid <= 1 for one cycle.
  - The accumulator returns to empty on the same edge.
- Latency: input edge to out_valid is LAT = L+1 cycles (4 for NI=8).
- Single-beat row (in_valid & in_last): output equals the lane sum of that beat.
- in_last with in_valid=0 is ignored.
- A new row may start on the cycle after a last beat. Its first beat starts from empty and never adds into the previous row.
- Cycles with in_valid=0 between beats of a row are bubbles only; the accumulator holds.
- busy=0 when idle; adder_output is stable while busy=0.

Optional Feature:
- Macro: RDA_SATURATE_EN.
- Defined:
  - Tree and accumulator additions saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Tree levels carry one guard bit per level, and the final tree sum is clamped to DATA_W before accumulation.
  - Extra output port sat_flag (1 bit) pulses with out_valid when any clamp occurred in that row; it resets to 0.
- Undefined: wrap-around arithmetic as above; sat_flag port absent.

Test Plan:
- NI=8, DATA_W=32. Three beats of all-ones lanes, last on beat 3, consecutive cycles -> out_valid exactly 4 cycles after beat 3, adder_output=24, beat_count=3, single pulse.
- Single beat with lanes 1..8 and in_last=1 -> adder_output=36, beat_count=1, out_valid 4 cycles later.
- Back-to-back rows: row A one beat of all 2 (last), row B next cycle one beat of all 3 (last) -> out_valid on consecutive cycles with 16 then 24; row B does not include row A.
- Bubbles: beat (all 1), 2 idle cycles, beat (all 1, last) -> adder_output=16; idle cycles change nothing.
- Assert rst (or drop start) after two beats of a four-beat row -> no out_valid. A following one-beat row of all 5 -> adder_output=40, beat_count=1.
- Lanes all 0x7FFFFFFF, one beat, last -> without RDA_SATURATE_EN adder_output=0xFFFFFFF8; with RDA_SATURATE_EN adder_output=0x7FFFFFFF and sat_flag=1.
